// File: rtl/gemm_act_skewer.sv
`default_nettype none
// ============================================================================
// Module   : gemm_act_skewer
// Brief    : Activation feeder for the weight-stationary systolic array.
//            Takes one unskewed ARRAY_SIZE-wide vector per accepted beat.
//            Emits it diagonally skewed, with lane c delayed c advances.
//            After the last vector it flushes the skew chains with zeros,
//            then pulses done.
// Optional : ACT_SKEW_STALL_CNT_EN adds the 16-bit stall_cycles output. It
//            counts FEED cycles with in_valid low and saturates at 0xFFFF.
// Revision : 1.0 - initial release
// ============================================================================
module gemm_act_skewer #(
  parameter int DATA_WIDTH  = 8,
  parameter int ARRAY_SIZE  = 16,
  parameter int MAX_VECTORS = 256
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [$clog2(MAX_VECTORS+1)-1:0]     num_vectors,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]     in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]     act_out,
  output logic                                 act_valid,
  output logic                                 act_last,
  output logic                                 busy,
  output logic                                 done
`ifdef ACT_SKEW_STALL_CNT_EN
  ,
  output logic [15:0]                          stall_cycles
`endif
);

  localparam int CNT_W = $clog2(MAX_VECTORS + 1);
  // The drain counter holds ARRAY_SIZE-2, so ARRAY_SIZE >= 2 always gives at least 1 bit.
  localparam int DRN_W = $clog2(ARRAY_SIZE);
  localparam logic [DRN_W-1:0] c_drain_init = DRN_W'(ARRAY_SIZE - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_advance;
  logic             w_start_ok;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [DRN_W-1:0] r_drain;
  logic             r_act_valid;
  logic             r_act_last;
  logic             r_done;

  // A job can start only from IDLE. Starts in every other state are ignored.
  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode, plus the state-only handshake and advance strobes
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (num_vectors != '0) ? S_FEED : S_DONE;
      end
      S_FEED: begin
        in_ready  = 1'b1;
        w_advance = in_valid;
        if (in_valid && (w_cnt_inc == r_num)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_advance = 1'b1;
        if (r_drain == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Job length latch, accepted-vector counter and drain down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num   <= '0;
      r_cnt   <= '0;
      r_drain <= '0;
    end else begin
      if (w_start_ok) begin
        r_num <= num_vectors;
        r_cnt <= '0;
      end else if ((r_state == S_FEED) && w_advance) begin
        r_cnt <= w_cnt_inc;
      end
      if ((r_state == S_FEED) && (w_state_nxt == S_DRAIN)) begin
        r_drain <= c_drain_init;
      end else if ((r_state == S_DRAIN) && (r_drain != '0)) begin
        r_drain <= r_drain - DRN_W'(1);
      end
    end
  end

  // Output strobes are registered so they line up with the chain tails
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_valid <= 1'b0;
      r_act_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_act_valid <= w_advance;
      r_act_last  <= (r_state == S_DRAIN) && (r_drain == '0);
      r_done      <= (r_state == S_DONE);
    end
  end

  assign act_valid = r_act_valid;
  assign act_last  = r_act_last;
  assign done      = r_done;
  assign busy      = (r_state != S_IDLE);

  // Lane c is a chain of c+1 registers, so element c of vector k
  // reaches the tail after advance k+c.
  for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_lane
    logic [DATA_WIDTH-1:0] r_stage [0:c];
    logic [DATA_WIDTH-1:0] w_lane_in;

    // DRAIN pushes zeros into the chain head.
    assign w_lane_in = (r_state == S_FEED) ? in_data[c*DATA_WIDTH +: DATA_WIDTH]
                                           : '0;

    // Shift on advance and hold on bubbles. Clear on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= c; s++) r_stage[s] <= '0;
      end else if (w_start_ok) begin
        for (int s = 0; s <= c; s++) r_stage[s] <= '0;
      end else if (w_advance) begin
        r_stage[0] <= w_lane_in;
        for (int s = 1; s <= c; s++) r_stage[s] <= r_stage[s-1];
      end
    end

    assign act_out[c*DATA_WIDTH +: DATA_WIDTH] = r_stage[c];
  end

`ifdef ACT_SKEW_STALL_CNT_EN
  logic [15:0] r_stall;

  // Count starved FEED cycles. The count saturates, and it holds after the job ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (w_start_ok) begin
      r_stall <= '0;
    end else if ((r_state == S_FEED) && !in_valid && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cycles = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gemm_act_skewer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gemm_act_skewer
// Brief    : Directed self-checking bench for gemm_act_skewer. A job table
//            is applied in a loop. Hand sequences then exercise zero-length
//            jobs and reset during DRAIN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gemm_act_skewer;

  localparam int DW = 8;
  localparam int AS = 16;
  localparam int MV = 256;
  localparam int VW = AS * DW;
  localparam int NW = $clog2(MV + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NW-1:0] num_vectors;
  logic [VW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] act_out;
  logic          act_valid;
  logic          act_last;
  logic          busy;
  logic          done;
`ifdef ACT_SKEW_STALL_CNT_EN
  logic [15:0]   stall_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  gemm_act_skewer #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .MAX_VECTORS(MV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_vectors (num_vectors),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .act_out     (act_out),
    .act_valid   (act_valid),
    .act_last    (act_last),
    .busy        (busy),
    .done        (done)
`ifdef ACT_SKEW_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // One job record: inputs and hand-computed expected totals
  typedef struct {
    int n;          // vectors in job
    int base;       // lane c of vector k carries base + 16k + c
    int gap_after;  // in_valid low before presenting this vector index
    int gap_len;    // number of low cycles
    int glitch;     // pulse start mid-FEED and during DONE
    int exp_beats;  // act_valid beats expected
    int exp_bubble; // act_valid-low cycles between first and last beat
    int exp_stall;  // expected stall_cycles
  } job_t;

  job_t jobs [6];

  task automatic chkv(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] vec(input int base, input int k);
    logic [VW-1:0] v;
    v = '0;
    for (int c = 0; c < AS; c++) v[c*DW +: DW] = DW'(base + 16*k + c);
    return v;
  endfunction

  // On beat t, lane c shows element c of vector t-c. Outside the job it shows zero.
  function automatic logic [VW-1:0] exp_beat(input int base, input int n, input int t);
    logic [VW-1:0] v;
    v = '0;
    for (int c = 0; c < AS; c++) begin
      if ((t - c >= 0) && (t - c < n)) v[c*DW +: DW] = DW'(base + 16*(t - c) + c);
    end
    return v;
  endfunction

  task automatic run_job(input job_t j);
    int k, gap_cnt, beats, bubbles, last_cyc, done_cyc, done_cnt;
    bit seen_first, done_seen, last_seen, glitched, accept;
    logic [VW-1:0] prev_out;
    k = 0; gap_cnt = 0; beats = 0; bubbles = 0; last_cyc = -10; done_cyc = -1; done_cnt = 0;
    seen_first = 0; done_seen = 0; last_seen = 0; glitched = 0;
    prev_out = '0;

    @(negedge clk);
    start = 1'b1; num_vectors = NW'(j.n); in_valid = 1'b0; in_data = '0;
    @(posedge clk); #1;
    start = 1'b0; num_vectors = '0;
    chkb("busy_after_start", busy, 1'b1);

    for (int cyc = 0; cyc < 100 && !done_seen; cyc++) begin
      start = 1'b0; num_vectors = '0;
      if (k < j.n) begin
        if (k == j.gap_after && gap_cnt < j.gap_len) begin
          in_valid = 1'b0; in_data = '0; gap_cnt++;
        end else begin
          in_valid = 1'b1; in_data = vec(j.base, k);
        end
        if (j.glitch != 0 && k == 1 && !glitched) begin
          start = 1'b1; num_vectors = NW'(7); glitched = 1;
        end
        chkb("in_ready_feed", in_ready, 1'b1);
      end else begin
        in_valid = 1'b0; in_data = '0;
        chkb("in_ready_nofeed", in_ready, 1'b0);
      end
      // act_last is visible during the DONE state. A start here must be ignored.
      if (j.glitch != 0 && last_seen) begin
        start = 1'b1; num_vectors = NW'(1);
      end
      accept = in_valid && in_ready;
      @(posedge clk); #1;
      if (accept) k++;
      last_seen = 0;
      if (act_valid) begin
        chkv($sformatf("beat%0d_data", beats), act_out, exp_beat(j.base, j.n, beats));
        chkb($sformatf("beat%0d_last", beats), act_last, (beats == j.n + AS - 2));
        if (act_last) begin last_cyc = cyc; last_seen = 1; end
        beats++;
        seen_first = 1;
      end else if (seen_first && beats < j.n + AS - 1) begin
        bubbles++;
        chkv("bubble_hold", act_out, prev_out);
      end
      prev_out = act_out;
      if (done) begin
        done_seen = 1; done_cyc = cyc; done_cnt++;
      end
    end
    start = 1'b0; num_vectors = '0; in_valid = 1'b0;

    chkb("done_seen", done_seen, 1'b1);
    chki("beats", beats, j.exp_beats);
    chki("bubbles", bubbles, j.exp_bubble);
    chki("done_after_last", done_cyc, last_cyc + 1);
    chkb("busy_at_done", busy, 1'b0);
`ifdef ACT_SKEW_STALL_CNT_EN
    chki("stall_cycles", int'(stall_cycles), j.exp_stall);
`endif
    @(posedge clk); #1;
    chkb("done_one_cycle", done, 1'b0);
    chkb("idle_after_done", busy, 1'b0);
    chkb("no_valid_after", act_valid, 1'b0);
  endtask

  initial begin
    bit done_flag;
    //          n  base    gap_after gap_len glitch beats bubble stall
    jobs[0] = '{1, 'h01,  -1, 0, 0, 16, 0, 0};
    jobs[1] = '{4, 'h00,  -1, 0, 0, 19, 0, 0};
    jobs[2] = '{3, 'h00,   2, 2, 0, 18, 2, 2};
    jobs[3] = '{3, 'h80,  -1, 0, 1, 18, 0, 0};
    jobs[4] = '{2, 'h40,  -1, 0, 0, 17, 0, 0};
    jobs[5] = '{5, 'h10,   0, 1, 0, 20, 0, 1};

    rst_n = 1'b0; start = 1'b0; num_vectors = '0; in_data = '0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chkv("rst_act_out", act_out, '0);
    chkb("rst_act_valid", act_valid, 1'b0);
    chkb("rst_act_last", act_last, 1'b0);
    chkb("rst_in_ready", in_ready, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", done, 1'b0);
`ifdef ACT_SKEW_STALL_CNT_EN
    chki("rst_stall", int'(stall_cycles), 0);
`endif
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_job(jobs[i]);

    // Zero-length job: done is expected two cycles after start, with no data.
    @(negedge clk); start = 1'b1; num_vectors = '0;
    @(posedge clk); #1; start = 1'b0;
    chkb("n0_busy", busy, 1'b1);
    chkb("n0_done_early", done, 1'b0);
    chkb("n0_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    chkb("n0_done", done, 1'b1);
    chkb("n0_act_valid", act_valid, 1'b0);
    chkb("n0_busy_end", busy, 1'b0);
    @(posedge clk); #1;
    chkb("n0_done_clear", done, 1'b0);

    // Reset during DRAIN: outputs clear at once and no done pulse follows.
    @(negedge clk); start = 1'b1; num_vectors = NW'(1); in_valid = 1'b1; in_data = vec(1, 0);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chkb("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chkv("arst_act_out", act_out, '0);
    chkb("arst_act_valid", act_valid, 1'b0);
    chkb("arst_act_last", act_last, 1'b0);
    chkb("arst_busy", busy, 1'b0);
    chkb("arst_in_ready", in_ready, 1'b0);
    chkb("arst_done", done, 1'b0);
    done_flag = 0;
    repeat (2) begin @(posedge clk); #1; if (done) done_flag = 1; end
    @(negedge clk); rst_n = 1'b1;
    repeat (20) begin @(posedge clk); #1; if (done || act_valid) done_flag = 1; end
    chkb("no_done_after_abort", done_flag, 1'b0);

    // A fresh single-vector job must match the first one exactly.
    run_job(jobs[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gemm_act_skewer.md
Name: gemm_act_skewer

Overview:
- Upstream feeder for the 16x16 weight-stationary systolic array.
- Accepts unskewed activation vectors (one ARRAY_SIZE-wide vector per beat) from the activation buffer over a valid/ready handshake.
- Emits them diagonally skewed: lane c delayed c beats relative to lane 0, ready to drive the array's activation_in/activation_valid.
- After the last vector, drains the skew pipeline with zero padding and signals done.

Parameters:
DATA_WIDTH, 8, activation element width
ARRAY_SIZE, 16, lanes (array columns); must be >= 2
MAX_VECTORS, 256, maximum vectors per job

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  job start pulse; sampled only in IDLE
num_vectors  input  $clog2(MAX_VECTORS+1)  vectors in job; latched on accepted start
in_data  input  ARRAY_SIZE x DATA_WIDTH  unskewed vector, element c for lane c
in_valid  input  1  in_data valid
in_ready  output  1  skewer accepts a vector this cycle
act_out  output  ARRAY_SIZE x DATA_WIDTH  skewed activations to array
act_valid  output  1  act_out valid (array advances only when high)
act_last  output  1  high with the final act_valid beat of the job
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at job end

Behaviour:
- Reset: state=IDLE, all delay registers=0, act_out=0, act_valid=0, act_last=0, in_ready=0, done=0, busy=0, latched count=0. Reset mid-job aborts immediately; no done pulse.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE -> FEED on start with num_vectors != 0; IDLE -> DONE on start with num_vectors == 0; start ignored in all other states.
- FEED:
  - in_ready=1.
  - advance = in_valid & in_ready.
  - accepted-vector counter increments per advance.
  - After the advance that accepts vector N-1, go to DRAIN.
- DRAIN:
  - in_ready=0; advance=1 every cycle, inserting zero vectors.
  - Lasts exactly ARRAY_SIZE-1 cycles (down-counter), then DONE.
- DONE: done=1 for one cycle -> IDLE.
- Skew datapath:
  - Lane c is a shift chain of c+1 registers; all chains shift only on advance cycles, otherwise hold (bubble freezes whole pipeline).
  - act_out[c] = tail of chain c.
  - act_valid is advance registered by one cycle.
  - Element c of vector k appears on act_out[c] in the cycle after advance number k+c (advances numbered from 0 per job).
  - Total act_valid beats per job = N+ARRAY_SIZE-1.
  - act_last = registered (DRAIN & final drain advance).
- Delay chains are cleared to 0 on each accepted start, so no data leaks between jobs.
- Output latency: first act_valid one cycle after first accepted vector; in_ready is combinational from state only (no dependency on in_valid).
- done and next-job start: start in the DONE cycle is ignored; earliest restart is the following cycle.

Optional Feature:
- Macro ACT_SKEW_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cycles (16 bits).
  - Counts FEED cycles with in_valid=0; saturates at 0xFFFF.
  - Cleared on accepted start and on reset; holds value after done.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Single vector (N=1), in_data lane c = c+1, in_valid held high:
  - act_valid high for 16 consecutive beats.
  - Beat b shows value b+1 on lane b and 0 on all other lanes.
  - act_last on beat 15; done one cycle after.
- N=4 back-to-back, vector k lane c = 16k+c:
  - 19 act_valid beats; on beat t, lane c = 16(t-c)+c when 0<=t-c<4, else 0.
  - busy deasserts after done.
- N=3 with in_valid low for 2 cycles between vectors 1 and 2:
  - act_valid drops for exactly 2 cycles; act_out holds during the bubble.
  - Lane sequence is identical to the no-bubble case.
  - stall_cycles=2 when ACT_SKEW_STALL_CNT_EN is defined.
- num_vectors=0: done pulses 2 cycles after start; act_valid never asserts; in_ready stays 0.
- Start pulsed mid-FEED and during DONE: ignored, with no change to count or output sequence.
- Back-to-back jobs: second job's early beats contain no residue of the first job.
- rst_n asserted mid-DRAIN: all outputs 0 asynchronously, no done pulse.
- Fresh N=1 job after reset: matches the single-vector case exactly.
